lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Shares the single LCD write port (feeding the LCD bus driver) among three masters:
//  the init sequencer (INIT), the menu/GUI drawer (GUI) and the CPU path (CPU).
//  Grants are burst-atomic. INIT has strict priority; GUI and CPU alternate round-robin.
//  The CPU master is gated by the core's cpu_draw level.
//  A watchdog reclaims the port from a stalled owner.
// PARAMETERS
//  DW       16     LCD data word width
//  TIMEOUT  1024   cycles without a handshake before an owner is evicted (>=2)
// PORTS
//  pclk         in   1      clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  cpu_en       in   1      CPU may own the bus (driven by core cpu_draw)
//  m_req        in   3      per-master request {CPU,GUI,INIT}, level
//  m_valid      in   3      per-master beat valid
//  m_dc         in   3      per-master data/command select (1=data)
//  m_data       in   3*DW   per-master word, master i at [i*DW +: DW]
//  m_last       in   3      beat is last of burst
//  m_ready      out  3      beat accepted (owner only)
//  lcd_valid    out  1      beat to bus driver
//  lcd_dc       out  1      data/command to bus driver
//  lcd_data     out  DW     word to bus driver
//  lcd_ready    in   1      bus driver accepts beat
//  owner        out  2      current owner index (0 INIT, 1 GUI, 2 CPU); 3 = none
//  busy         out  1      state == BUSY
//  timeout_p    out  1      1-cycle pulse: owner evicted by watchdog
//  abort_p      out  1      1-cycle pulse: CPU burst cut by cpu_en fall
// BEHAVIOUR
//  - Reset: state=IDLE, owner=3, rr_gui_next=1; m_ready=0, lcd_valid=0, lcd_dc=0,
//    lcd_data=0, busy=0, timeout_p=0, abort_p=0, wdog=0.
//  - States: IDLE, BUSY.
//  - IDLE: eff_req = m_req & {cpu_en,1,1}.
//    - INIT wins if requesting. Otherwise GUI vs CPU per rr_gui_next.
//    - If only one of GUI/CPU is requesting, it wins.
//    - Winner is registered into owner and state goes to BUSY. Grant latency 1 cycle.
//    - rr_gui_next is toggled away from the GUI/CPU winner. INIT grants leave it unchanged.
//  - BUSY, datapath combinational from owner:
//    - lcd_valid = m_valid[owner]; lcd_dc/lcd_data = owner's fields.
//    - m_ready[owner] = lcd_ready; non-owners see m_ready=0.
//    - Outside BUSY: lcd_valid=0, lcd_dc=0, lcd_data=0.
//  - Handshake = lcd_valid & lcd_ready.
//    - Handshake with m_last[owner]=1: go to IDLE, owner=3.
//    - Next arbitration happens in the following cycle: exactly one idle cycle between bursts.
//  - m_req dropping mid-burst does not release the grant. Only last, timeout or abort release it.
//  - Watchdog: wdog counts BUSY cycles with no handshake and clears on handshake or grant.
//    - At wdog == TIMEOUT-1 with no handshake in that cycle: release to IDLE, timeout_p=1.
//    - Counter width $clog2(TIMEOUT).
//  - Abort: owner==CPU and cpu_en==0 in BUSY releases to IDLE next edge and pulses abort_p.
//    - A handshake in that same cycle still completes (m_ready follows lcd_ready).
//  - Priority of simultaneous release causes: last-handshake > abort > timeout.
//    Only one pulse fires per cycle.
//  - INIT does not preempt an in-flight GUI/CPU burst. It waits for the boundary.
//  - Reset asserted mid-burst: immediate return to reset values on that edge.
//    The beat in flight is dropped.
// STRUCTURE
//  - lcd_pkg (shared):
//    - LCD_M_INIT=2'd0, LCD_M_GUI=2'd1, LCD_M_CPU=2'd2, LCD_M_NONE=2'd3
//    - typedef enum logic {ARB_IDLE, ARB_BUSY} lcd_arb_state_t
//  - Sub-module lcd_arb_pick: combinational; inputs eff_req[2:0], rr_gui_next; outputs winner[1:0], any.
//  - Top holds the FSM, watchdog, owner register and output mux.
// TESTING
//  1. INIT and GUI req same cycle, INIT 3-beat burst, lcd_ready=1
//     -> owner=0 next cycle; 3 beats pass in 3 cycles; 1 idle cycle; then owner=1.
//  2. GUI and CPU both continuously requesting 1-beat bursts, cpu_en=1
//     -> owners alternate 1,2,1,2; each grant separated by one idle cycle.
//  3. CPU req with cpu_en=0
//     -> never granted, m_ready[2]=0.
//     Then CPU owns and cpu_en falls mid-burst -> abort_p one cycle, owner=3 next cycle.
//  4. TIMEOUT=8, GUI granted with m_valid=0
//     -> timeout_p exactly 8 cycles after grant, owner=3.
//     A handshake at cycle 5 restarts the count.
//  5. lcd_ready toggling 1/0 during a 4-beat CPU burst
//     -> lcd_data sequence matches source order with no duplicates or drops.
//     Non-owner m_ready stays 0.
//  6. rst pulsed during a GUI burst
//     -> all outputs at reset values the next cycle; re-arbitration works afterward.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write-port arbiter: master indices, FSM states
// and the round-robin pointer update.
package lcd_pkg;

  localparam logic [1:0] LCD_M_INIT = 2'd0;
  localparam logic [1:0] LCD_M_GUI  = 2'd1;
  localparam logic [1:0] LCD_M_CPU  = 2'd2;
  localparam logic [1:0] LCD_M_NONE = 2'd3;

  typedef enum logic {ARB_IDLE, ARB_BUSY} lcd_arb_state_t;

  // Point the GUI/CPU round-robin away from whoever just won; INIT leaves it alone.
  function automatic logic rr_update(input logic [1:0] winner, input logic rr_gui_next);
    logic rr;
    rr = rr_gui_next;
    if (winner == LCD_M_GUI) rr = 1'b0;
    if (winner == LCD_M_CPU) rr = 1'b1;
    return rr;
  endfunction

endpackage

// File: rtl/lcd_arb_pick.sv
// Combinational winner selection: INIT has strict priority, GUI/CPU share by round-robin.
module lcd_arb_pick
  import lcd_pkg::*;
(
  input  logic [2:0] eff_req,
  input  logic       rr_gui_next,
  output logic [1:0] winner,
  output logic       any
);

  always_comb begin
    any    = |eff_req;
    winner = LCD_M_NONE;
    if (eff_req[0]) begin
      winner = LCD_M_INIT;
    end else if (eff_req[1] && eff_req[2]) begin
      winner = rr_gui_next ? LCD_M_GUI : LCD_M_CPU;
    end else if (eff_req[1]) begin
      winner = LCD_M_GUI;
    end else if (eff_req[2]) begin
      winner = LCD_M_CPU;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Burst-atomic arbiter sharing the LCD write port among INIT, GUI and CPU masters,
// with a no-progress watchdog and CPU abort on cpu_en fall.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            cpu_en,
  input  logic [2:0]      m_req,
  input  logic [2:0]      m_valid,
  input  logic [2:0]      m_dc,
  input  logic [3*DW-1:0] m_data,
  input  logic [2:0]      m_last,
  output logic [2:0]      m_ready,
  output logic            lcd_valid,
  output logic            lcd_dc,
  output logic [DW-1:0]   lcd_data,
  input  logic            lcd_ready,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            timeout_p,
  output logic            abort_p
);

  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WdogMax = WW'(TIMEOUT - 1);

  lcd_arb_state_t state_q, state_d;
  logic [1:0]     owner_q, owner_d;
  logic           rr_gui_next_q, rr_gui_next_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           timeout_q, timeout_d;
  logic           abort_q, abort_d;

  logic [2:0] eff_req;
  logic [1:0] winner;
  logic       any;
  logic       sel_last;
  logic       handshake;

  assign eff_req = m_req & {cpu_en, 2'b11};

  lcd_arb_pick u_pick (
    .eff_req     (eff_req),
    .rr_gui_next (rr_gui_next_q),
    .winner      (winner),
    .any         (any)
  );

  // Datapath is a pure mux on the registered owner; nothing leaks outside BUSY.
  always_comb begin
    m_ready   = '0;
    lcd_valid = 1'b0;
    lcd_dc    = 1'b0;
    lcd_data  = '0;
    sel_last  = 1'b0;
    if (state_q == ARB_BUSY) begin
      for (int i = 0; i < 3; i++) begin
        if (owner_q == 2'(i)) begin
          lcd_valid  = m_valid[i];
          lcd_dc     = m_dc[i];
          lcd_data   = m_data[i*DW +: DW];
          sel_last   = m_last[i];
          m_ready[i] = lcd_ready;
        end
      end
    end
  end

  assign handshake = lcd_valid & lcd_ready;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_gui_next_d = rr_gui_next_q;
    wdog_d        = wdog_q;
    timeout_d     = 1'b0;
    abort_d       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          state_d       = ARB_BUSY;
          owner_d       = winner;
          wdog_d        = '0;
          rr_gui_next_d = rr_update(winner, rr_gui_next_q);
        end
      end
      ARB_BUSY: begin
        // Release causes in priority order: clean end of burst, abort, watchdog.
        if (handshake && sel_last) begin
          state_d = ARB_IDLE;
          owner_d = LCD_M_NONE;
          wdog_d  = '0;
        end else if (owner_q == LCD_M_CPU && !cpu_en) begin
          state_d = ARB_IDLE;
          owner_d = LCD_M_NONE;
          wdog_d  = '0;
          abort_d = 1'b1;
        end else if (!handshake && wdog_q == WdogMax) begin
          state_d   = ARB_IDLE;
          owner_d   = LCD_M_NONE;
          wdog_d    = '0;
          timeout_d = 1'b1;
        end else if (handshake) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= LCD_M_NONE;
      rr_gui_next_q <= 1'b1;
      wdog_q        <= '0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_gui_next_q <= rr_gui_next_d;
      wdog_q        <= wdog_d;
      timeout_q     <= timeout_d;
      abort_q       <= abort_d;
    end
  end

  assign owner     = owner_q;
  assign busy      = (state_q == ARB_BUSY);
  assign timeout_p = timeout_q;
  assign abort_p   = abort_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed vector table, corner-case sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_lcd_bus_arbiter;

  localparam int DW = 16;
  localparam int TO = 8;

  logic            pclk = 1'b0;
  logic            rst = 1'b1;
  logic            cpu_en = 1'b1;
  logic [2:0]      m_req = '0;
  logic [2:0]      m_valid = '0;
  logic [2:0]      m_dc = '0;
  logic [3*DW-1:0] m_data = '0;
  logic [2:0]      m_last = '0;
  logic            lcd_ready = 1'b0;
  logic [2:0]      m_ready;
  logic            lcd_valid;
  logic            lcd_dc;
  logic [DW-1:0]   lcd_data;
  logic [1:0]      owner;
  logic            busy;
  logic            timeout_p;
  logic            abort_p;

  int checks = 0;
  int errors = 0;

  lcd_bus_arbiter #(
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .cpu_en    (cpu_en),
    .m_req     (m_req),
    .m_valid   (m_valid),
    .m_dc      (m_dc),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .lcd_valid (lcd_valid),
    .lcd_dc    (lcd_dc),
    .lcd_data  (lcd_data),
    .lcd_ready (lcd_ready),
    .owner     (owner),
    .busy      (busy),
    .timeout_p (timeout_p),
    .abort_p   (abort_p)
  );

  always #5 pclk = ~pclk;

  // Behavioural model: who owns the port, whose turn it is, how long the owner has stalled.
  int mo     = 3;
  bit mrr    = 1'b1;
  int mstall = 0;
  bit mtp    = 1'b0;
  bit map    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_outs();
    logic          lv, ld;
    logic [DW-1:0] dat;
    logic [2:0]    mr;
    lv = 1'b0; ld = 1'b0; dat = '0; mr = '0;
    if (mo != 3) begin
      lv     = m_valid[mo];
      ld     = m_dc[mo];
      dat    = m_data[mo*DW +: DW];
      mr[mo] = lcd_ready;
    end
    return 64'({2'(mo), (mo != 3), lv, ld, dat, mr, mtp, map});
  endfunction

  function automatic logic [63:0] dut_outs();
    return 64'({owner, busy, lcd_valid, lcd_dc, lcd_data, m_ready, timeout_p, abort_p});
  endfunction

  task automatic model_update();
    logic [2:0] eff;
    bit         hs;
    mtp = 1'b0;
    map = 1'b0;
    if (rst) begin
      mo = 3; mrr = 1'b1; mstall = 0;
      return;
    end
    if (mo == 3) begin
      eff = m_req & {cpu_en, 2'b11};
      if (eff[0]) mo = 0;
      else if (eff[1] && (mrr || !eff[2])) begin mo = 1; mrr = 1'b0; end
      else if (eff[2]) begin mo = 2; mrr = 1'b1; end
      mstall = 0;
    end else begin
      hs = m_valid[mo] && lcd_ready;
      if (hs && m_last[mo]) mo = 3;
      else if (mo == 2 && !cpu_en) begin mo = 3; map = 1'b1; end
      else if (!hs && mstall == TO - 1) begin mo = 3; mtp = 1'b1; end
      else mstall = hs ? 0 : mstall + 1;
    end
  endtask

  task automatic settle();
    #1;
    chk("model", dut_outs(), model_outs());
  endtask

  task automatic advance();
    @(posedge pclk);
    model_update();
    @(negedge pclk);
  endtask

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] req;
    logic [2:0] val;
    logic [2:0] last;
    logic       rdy;
    logic [1:0] e_owner;
    logic       e_busy;
    logic       e_lv;
    logic [2:0] e_mr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[10];
  int   exp_rr[8];
  logic [15:0] src[4];
  logic [15:0] got_q[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int got, k, c;
    bit took;

    tbl[0] = '{1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 3'b011, 3'b001, 3'b000, 1'b1, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 3'b011, 3'b001, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 16'hA11A};
    tbl[3] = '{1'b0, 1'b1, 3'b011, 3'b001, 3'b000, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 16'hA11A};
    tbl[4] = '{1'b0, 1'b1, 3'b011, 3'b001, 3'b001, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 16'hA11A};
    tbl[5] = '{1'b0, 1'b1, 3'b010, 3'b010, 3'b010, 1'b1, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, 1'b1, 1'b1, 3'b010, 16'hB00B};
    tbl[7] = '{1'b0, 1'b0, 3'b100, 3'b100, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[8] = '{1'b0, 1'b0, 3'b100, 3'b100, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    tbl[9] = '{1'b0, 1'b0, 3'b100, 3'b100, 3'b100, 1'b1, 2'd3, 1'b0, 1'b0, 3'b000, 16'h0000};
    exp_rr = '{3, 2, 3, 1, 3, 2, 3, 1};
    src    = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};

    @(negedge pclk);

    // Reset, INIT beats GUI, 3-beat burst, one idle cycle, then GUI; CPU gated off.
    m_data = {16'hC0DE, 16'hB00B, 16'hA11A};
    m_dc   = 3'b101;
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; cpu_en = tbl[i].en; m_req = tbl[i].req;
      m_valid = tbl[i].val; m_last = tbl[i].last; lcd_ready = tbl[i].rdy;
      settle();
      chk($sformatf("vec%0d", i), {owner, busy, lcd_valid, m_ready, lcd_data},
          {tbl[i].e_owner, tbl[i].e_busy, tbl[i].e_lv, tbl[i].e_mr, tbl[i].e_data});
      advance();
    end

    // GUI and CPU alternate with one idle cycle between single-beat bursts.
    cpu_en = 1'b1; m_req = 3'b110; m_valid = 3'b110; m_last = 3'b110; lcd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("rr_owner%0d", i), owner, exp_rr[i]);
      advance();
    end

    // CPU abort: beat in the abort cycle still handshakes, pulse arrives with release.
    m_req = 3'b100; m_valid = 3'b100; m_last = 3'b000;
    settle();
    chk("abort_pre_idle", owner, 2'd3);
    advance();
    cpu_en = 1'b0;
    settle();
    chk("abort_owner_cpu", owner, 2'd2);
    chk("abort_beat_ready", m_ready, 3'b100);
    chk("abort_not_yet", abort_p, 1'b0);
    advance();
    cpu_en = 1'b1; m_req = 3'b000; m_valid = 3'b000;
    settle();
    chk("abort_pulse", {owner, abort_p, timeout_p}, {2'd3, 1'b1, 1'b0});
    advance();
    settle();
    chk("abort_pulse_end", abort_p, 1'b0);
    advance();

    // Watchdog: stalled GUI evicted 8 cycles after grant.
    m_req = 3'b010; m_valid = 3'b000; m_last = 3'b000; lcd_ready = 1'b1;
    settle();
    advance();
    got = -1;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (timeout_p) begin got = i; break; end
      advance();
    end
    chk("timeout_at", got, 8);
    chk("timeout_owner", owner, 2'd3);
    advance();
    // A handshake at cycle 5 restarts the count.
    got = -1;
    for (int i = 0; i < 30; i++) begin
      m_valid = (i == 5) ? 3'b010 : 3'b000;
      settle();
      if (timeout_p) begin got = i; break; end
      advance();
    end
    chk("timeout_restart_at", got, 14);
    advance();
    m_req = 3'b000; m_valid = 3'b010; m_last = 3'b010;
    settle();
    advance();
    m_valid = 3'b000; m_last = 3'b000;

    // 4-beat CPU burst with lcd_ready toggling: order preserved, no dup/drop.
    m_req = 3'b100; m_valid = 3'b100; cpu_en = 1'b1;
    k = 0; c = 0;
    while (k < 4 && c < 30) begin
      m_data[2*DW +: DW] = src[k];
      m_last = (k == 3) ? 3'b100 : 3'b000;
      lcd_ready = ((c % 2) == 1);
      settle();
      chk("nonowner_ready", m_ready[1:0], 2'b00);
      if (lcd_valid && lcd_ready) got_q.push_back(lcd_data);
      took = m_ready[2];
      advance();
      if (took) k++;
      c++;
    end
    chk("burst_len", got_q.size(), 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("burst_word%0d", j), (j < got_q.size()) ? got_q[j] : 16'hxxxx, src[j]);
    m_req = 3'b000; m_valid = 3'b000; m_last = 3'b000;

    // Reset mid GUI burst, then re-arbitration.
    m_req = 3'b010; m_valid = 3'b010; lcd_ready = 1'b1;
    settle();
    advance();
    settle();
    chk("rst_burst_beat", {owner, lcd_valid}, {2'd1, 1'b1});
    advance();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    settle();
    chk("rst_outputs", dut_outs(), 64'({2'd3, 24'h000000}));
    advance();
    settle();
    chk("rst_regrant", owner, 2'd1);
    advance();

    // Randomized run against the model, with periodic stall windows to hit the watchdog.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cpu_en    = ($urandom_range(0, 9) != 0);
      m_req     = 3'($urandom);
      m_valid   = 3'($urandom);
      m_dc      = 3'($urandom);
      m_last    = 3'($urandom) & 3'($urandom);
      m_data    = 48'({$urandom, $urandom});
      lcd_ready = ((n % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      settle();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
